div_error_monitor: RTL and testbench

Sequential checker that sits directly downstream of the 16/8 array dividers, approximate or exact. For each handshaked sample it takes the divider's operands and its quotient/remainder outputs, recomputes the exact result with an 8-step iterative restoring divider, and accumulates error statistics. The delay-MAE heuristic flow reads these statistics to score an approximate-cell configuration in simulation or on FPGA.

---
 rtl/div_mon_pkg.sv | 23 ++
 rtl/div_restoring_iter.sv | 65 ++++++
 rtl/div_error_monitor.sv | 166 ++++++++++++++++
 tb/tb_div_error_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divider error monitor.
// Holds the operand widths, the monitor state encoding and a saturating adder.
package div_mon_pkg;

    localparam int N_W = 16;
    localparam int D_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACC  = 2'd2
    } mon_state_t;

    // Adds a and b and clamps the result to the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/div_restoring_iter.sv
// One-bit-per-cycle restoring divider used as the exact reference.
// start loads the high dividend byte; each step cycle retires one quotient bit, MSB first.
module div_restoring_iter
    import div_mon_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d,
    output logic [D_W-1:0] q,
    output logic [D_W-1:0] r,
    output logic           done
);

    logic [D_W:0]   rem_q, rem_d;
    logic [D_W-1:0] quo_q, quo_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2:0]     bit_idx;
    logic           n_bit;
    logic [D_W:0]   rem9;

    always_comb begin
        bit_idx = 3'd7 - cnt_q;
        n_bit   = n[{1'b0, bit_idx}];
        // The partial remainder is always below d, so the shifted value fits in 9 bits.
        rem9    = (rem_q << 1) | {{D_W{1'b0}}, n_bit};
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (start) begin
            rem_d = {1'b0, n[N_W-1:D_W]};
            quo_d = '0;
            cnt_d = '0;
        end else if (step) begin
            if (rem9 >= {1'b0, d}) begin
                rem_d = rem9 - {1'b0, d};
                quo_d = {quo_q[D_W-2:0], 1'b1};
            end else begin
                rem_d = rem9;
                quo_d = {quo_q[D_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 3'd1;
            done  = (cnt_q == 3'd7);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    assign q = quo_q;
    assign r = rem_q[D_W-1:0];

endmodule

// File: rtl/div_error_monitor.sv
// Scores an approximate 16/8 divider against an exact restoring divider and accumulates error stats.
// Handshake: a sample transfers on a rising edge where in_valid && in_ready; inputs matter only on that edge.
module div_error_monitor
    import div_mon_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   n,
    input  logic [D_W-1:0]   d,
    input  logic [D_W-1:0]   q_apx,
    input  logic [D_W-1:0]   r_apx,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] mis_cnt,
    output logic [ACC_W-1:0] q_err_sum,
    output logic [ACC_W-1:0] r_err_sum,
    output logic [D_W-1:0]   q_err_max,
    output mon_state_t       dbg_state
);

    mon_state_t     state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic [N_W-1:0] n_q, n_d;
    logic [D_W-1:0] d_q, d_d;
    logic [D_W-1:0] q_apx_q, q_apx_d;
    logic [D_W-1:0] r_apx_q, r_apx_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [ACC_W-1:0] q_err_sum_q, q_err_sum_d;
    logic [ACC_W-1:0] r_err_sum_q, r_err_sum_d;
    logic [D_W-1:0]   q_err_max_q, q_err_max_d;

    logic           calc_start;
    logic           calc_done;
    logic           out_of_range;
    logic [D_W-1:0] q_exact, r_exact;
    logic [D_W-1:0] q_diff, r_diff;

    // Fed with the next-state latch values so the divider sees the live inputs on the accepting edge.
    div_restoring_iter u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (calc_start),
        .step  (state_q == CALC),
        .n     (n_d),
        .d     (d_d),
        .q     (q_exact),
        .r     (r_exact),
        .done  (calc_done)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        d_d          = d_q;
        q_apx_d      = q_apx_q;
        r_apx_d      = r_apx_q;
        sample_cnt_d = sample_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        q_err_sum_d  = q_err_sum_q;
        r_err_sum_d  = r_err_sum_q;
        q_err_max_d  = q_err_max_q;
        calc_start   = 1'b0;
        out_of_range = (d == '0) || (n[N_W-1:D_W] >= d);
        q_diff       = (q_exact >= q_apx_q) ? (q_exact - q_apx_q) : (q_apx_q - q_exact);
        r_diff       = (r_exact >= r_apx_q) ? (r_exact - r_apx_q) : (r_apx_q - r_exact);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d     = n;
                    d_d     = d;
                    q_apx_d = q_apx;
                    r_apx_d = r_apx;
                    if (out_of_range) begin
                        skip_cnt_d = CNT_W'(sat_add(32'(skip_cnt_q), 32'd1, CNT_W));
                    end else begin
                        calc_start = 1'b1;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                if (calc_done) state_d = ACC;
            end
            ACC: begin
                q_err_sum_d  = ACC_W'(sat_add(32'(q_err_sum_q), 32'(q_diff), ACC_W));
                r_err_sum_d  = ACC_W'(sat_add(32'(r_err_sum_q), 32'(r_diff), ACC_W));
                q_err_max_d  = (q_diff > q_err_max_q) ? q_diff : q_err_max_q;
                sample_cnt_d = CNT_W'(sat_add(32'(sample_cnt_q), 32'd1, CNT_W));
                if ((q_diff != '0) || (r_diff != '0))
                    mis_cnt_d = CNT_W'(sat_add(32'(mis_cnt_q), 32'd1, CNT_W));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides everything, including a sample sitting in ACC.
        if (clr) begin
            state_d      = IDLE;
            calc_start   = 1'b0;
            sample_cnt_d = '0;
            skip_cnt_d   = '0;
            mis_cnt_d    = '0;
            q_err_sum_d  = '0;
            r_err_sum_d  = '0;
            q_err_max_d  = '0;
        end

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            n_q          <= '0;
            d_q          <= '0;
            q_apx_q      <= '0;
            r_apx_q      <= '0;
            sample_cnt_q <= '0;
            skip_cnt_q   <= '0;
            mis_cnt_q    <= '0;
            q_err_sum_q  <= '0;
            r_err_sum_q  <= '0;
            q_err_max_q  <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            n_q          <= n_d;
            d_q          <= d_d;
            q_apx_q      <= q_apx_d;
            r_apx_q      <= r_apx_d;
            sample_cnt_q <= sample_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
            q_err_sum_q  <= q_err_sum_d;
            r_err_sum_q  <= r_err_sum_d;
            q_err_max_q  <= q_err_max_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign sample_cnt = sample_cnt_q;
    assign skip_cnt   = skip_cnt_q;
    assign mis_cnt    = mis_cnt_q;
    assign q_err_sum  = q_err_sum_q;
    assign r_err_sum  = r_err_sum_q;
    assign q_err_max  = q_err_max_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_div_error_monitor.sv
// Bench for div_error_monitor: directed table, multi-cycle clear/reset sequences and random samples.
// Two instances share stimulus; the ACC_W=8 copy exposes sum saturation.
module tb_div_error_monitor;
  import div_mon_pkg::*;

  logic clk = 1'b0;
  logic rst, clr, in_valid;
  logic [15:0] n;
  logic [7:0] d, q_apx, r_apx;

  logic in_ready, busy;
  logic [15:0] sample_cnt, skip_cnt, mis_cnt;
  logic [23:0] q_err_sum, r_err_sum;
  logic [7:0] q_err_max;
  mon_state_t dbg_state;

  logic in_ready_8, busy_8;
  logic [15:0] sample_cnt_8, skip_cnt_8, mis_cnt_8;
  logic [7:0] q_err_sum_8, r_err_sum_8;
  logic [7:0] q_err_max_8;
  mon_state_t dbg_state_8;

  int tests = 0;
  int fails = 0;

  int m_sample, m_skip, m_mis, m_qsum, m_rsum, m_qmax, m_qsum8, m_rsum8;

  typedef struct {
    logic [15:0] n;
    logic [7:0] d;
    logic [7:0] qa;
    logic [7:0] ra;
    int e_smp;
    int e_skip;
    int e_mis;
    int e_qs;
    int e_rs;
    int e_qm;
  } vec_t;

  vec_t vecs[8];

  div_error_monitor #(.ACC_W(24), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx), .busy(busy),
    .sample_cnt(sample_cnt), .skip_cnt(skip_cnt), .mis_cnt(mis_cnt),
    .q_err_sum(q_err_sum), .r_err_sum(r_err_sum), .q_err_max(q_err_max),
    .dbg_state(dbg_state)
  );

  div_error_monitor #(.ACC_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_8),
    .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx), .busy(busy_8),
    .sample_cnt(sample_cnt_8), .skip_cnt(skip_cnt_8), .mis_cnt(mis_cnt_8),
    .q_err_sum(q_err_sum_8), .r_err_sum(r_err_sum_8), .q_err_max(q_err_max_8),
    .dbg_state(dbg_state_8)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sample = 0; m_skip = 0; m_mis = 0; m_qsum = 0; m_rsum = 0;
    m_qmax = 0; m_qsum8 = 0; m_rsum8 = 0;
  endtask

  // Reference: exact division by plain arithmetic, statistics kept as integers.
  task automatic model_apply(input int ni, input int di, input int qa, input int ra);
    int qe, re, qd, rd;
    if (di == 0 || ni / di > 255) begin
      m_skip++;
    end else begin
      qe = ni / di;
      re = ni % di;
      qd = (qe > qa) ? qe - qa : qa - qe;
      rd = (re > ra) ? re - ra : ra - re;
      m_sample++;
      if (qd != 0 || rd != 0) m_mis++;
      m_qsum = (m_qsum + qd > 16777215) ? 16777215 : m_qsum + qd;
      m_rsum = (m_rsum + rd > 16777215) ? 16777215 : m_rsum + rd;
      m_qsum8 = (m_qsum8 + qd > 255) ? 255 : m_qsum8 + qd;
      m_rsum8 = (m_rsum8 + rd > 255) ? 255 : m_rsum8 + rd;
      if (qd > m_qmax) m_qmax = qd;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // driver: leaves the bench at the negedge just after the accepting edge
  task automatic accept(input logic [15:0] an, input logic [7:0] ad, input logic [7:0] aq, input logic [7:0] ar);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; n = an; d = ad; q_apx = aq; r_apx = ar;
    @(negedge clk);
    in_valid = 1'b0;
    n = 16'($urandom); d = 8'($urandom); q_apx = 8'($urandom); r_apx = 8'($urandom);
  endtask

  task automatic send(input logic [15:0] an, input logic [7:0] ad, input logic [7:0] aq, input logic [7:0] ar);
    int k;
    bit in_range;
    in_range = (ad != 0) && (int'(an) / int'(ad) <= 255);
    accept(an, ad, aq, ar);
    check("busy_after_accept", 32'(busy), in_range ? 32'd1 : 32'd0);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_latency", 32'(k), in_range ? 32'd9 : 32'd0);
    if (in_range) @(negedge clk);
    model_apply(int'(an), int'(ad), int'(aq), int'(ar));
  endtask

  task automatic check_stats(input string tag, input int s, input int k, input int m,
                             input int qs, input int rs, input int qm);
    check({tag, ".sample_cnt"}, 32'(sample_cnt), 32'(s));
    check({tag, ".skip_cnt"}, 32'(skip_cnt), 32'(k));
    check({tag, ".mis_cnt"}, 32'(mis_cnt), 32'(m));
    check({tag, ".q_err_sum"}, 32'(q_err_sum), 32'(qs));
    check({tag, ".r_err_sum"}, 32'(r_err_sum), 32'(rs));
    check({tag, ".q_err_max"}, 32'(q_err_max), 32'(qm));
  endtask

  task automatic check_model(input string tag);
    check_stats(tag, m_sample, m_skip, m_mis, m_qsum, m_rsum, m_qmax);
    check({tag, ".q_err_sum_8"}, 32'(q_err_sum_8), 32'(m_qsum8));
    check({tag, ".r_err_sum_8"}, 32'(r_err_sum_8), 32'(m_rsum8));
    check({tag, ".sample_cnt_8"}, 32'(sample_cnt_8), 32'(m_sample));
  endtask

  task automatic abort_test(input bit use_rst);
    string tag;
    tag = use_rst ? "abort_rst" : "abort_clr";
    do_reset();
    send(16'd100, 8'd7, 8'd12, 8'd0);
    accept(16'd100, 8'd7, 8'd14, 8'd2);
    repeat (3) @(negedge clk);
    check({tag, ".state_calc"}, 32'(dbg_state), 32'(CALC));
    if (use_rst) rst = 1'b1; else clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; clr = 1'b0;
    check_stats(tag, 0, 0, 0, 0, 0, 0);
    check({tag, ".state_idle"}, 32'(dbg_state), 32'(IDLE));
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check({tag, ".not_counted"}, 32'(sample_cnt), 32'd0);
    model_reset();
  endtask

  initial begin
    int ni, di, qa, ra, qe, re, mode;

    // directed table: each entry runs from reset, expected stats computed by hand
    vecs[0] = '{16'd100,   8'd7,   8'd14,  8'd2,   1, 0, 0, 0,   0,   0};
    vecs[1] = '{16'd100,   8'd7,   8'd12,  8'd0,   1, 0, 1, 2,   2,   2};
    vecs[2] = '{16'd1234,  8'd0,   8'd0,   8'd0,   0, 1, 0, 0,   0,   0};
    vecs[3] = '{16'h0800,  8'd8,   8'd0,   8'd0,   0, 1, 0, 0,   0,   0};
    vecs[4] = '{16'h7FFF,  8'd255, 8'd0,   8'd0,   1, 0, 1, 128, 127, 128};
    vecs[5] = '{16'h00FF,  8'd1,   8'd200, 8'd5,   1, 0, 1, 55,  5,   55};
    vecs[6] = '{16'hFEFF,  8'd255, 8'd255, 8'd254, 1, 0, 0, 0,   0,   0};
    vecs[7] = '{16'd0,     8'd5,   8'd3,   8'd9,   1, 0, 1, 3,   9,   3};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    n = '0; d = '0; q_apx = '0; r_apx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();

    check_stats("reset", 0, 0, 0, 0, 0, 0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.state", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(vecs[i].n, vecs[i].d, vecs[i].qa, vecs[i].ra);
      check_stats($sformatf("vec%0d", i), vecs[i].e_smp, vecs[i].e_skip, vecs[i].e_mis,
                  vecs[i].e_qs, vecs[i].e_rs, vecs[i].e_qm);
    end

    // two back-to-back out-of-range samples
    do_reset();
    send(16'h1234, 8'd0, 8'd1, 8'd1);
    send(16'h0800, 8'd8, 8'd1, 8'd1);
    check_stats("skip_pair", 0, 2, 0, 0, 0, 0);
    check("skip_pair.in_ready", 32'(in_ready), 32'd1);

    abort_test(1'b0);
    abort_test(1'b1);

    // clear landing in the ACC cycle wins over accumulation
    do_reset();
    send(16'd100, 8'd7, 8'd12, 8'd0);
    accept(16'd100, 8'd7, 8'd12, 8'd0);
    repeat (8) @(negedge clk);
    check("clr_acc.state_acc", 32'(dbg_state), 32'(ACC));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_stats("clr_acc", 0, 0, 0, 0, 0, 0);
    check("clr_acc.state_idle", 32'(dbg_state), 32'(IDLE));
    model_reset();

    // sum saturation on the 8-bit accumulator copy
    do_reset();
    for (int i = 0; i < 3; i++) send(16'd100, 8'd7, 8'd114, 8'd2);
    check("sat.q_err_sum_8", 32'(q_err_sum_8), 32'd255);
    check("sat.q_err_sum", 32'(q_err_sum), 32'd300);
    check("sat.q_err_max_8", 32'(q_err_max_8), 32'd100);
    check_model("sat");

    // random samples against the arithmetic model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      di = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      ni = int'($urandom_range(0, 65535));
      if (di != 0 && $urandom_range(0, 3) != 0)
        ni = int'($urandom_range(0, di - 1)) * 256 + int'($urandom_range(0, 255));
      qe = (di != 0) ? (ni / di) % 256 : 0;
      re = (di != 0) ? (ni % di) % 256 : 0;
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        qa = qe; ra = re;
      end else if (mode == 1) begin
        qa = (qe + int'($urandom_range(0, 20))) % 256;
        ra = (re + int'($urandom_range(0, 3))) % 256;
      end else begin
        qa = int'($urandom_range(0, 255));
        ra = int'($urandom_range(0, 255));
      end
      send(16'(ni), 8'(di), 8'(qa), 8'(ra));
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
